// File: rtl/regbus_pkg.sv
// Shared definitions for the register-bus sequencer: bus/index widths and FSM state encoding.
package regbus_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREG  = 32;
    localparam int unsigned IDX_W = $clog2(NREG);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        EXEC,
        WR
    } seq_state_t;

endpackage

// File: rtl/regbus_sequencer.sv
// Initiator on the shared register-file bus: reads rs1/rs2, presents operands to the execute unit,
// then writes the result back to rd. Sole driver of reg_idx/reg_en/reg_write and the bus write half.
module regbus_sequencer
    import regbus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_rs1,
    input  logic [IDX_W-1:0] req_rs2,
    input  logic             req_use2,
    input  logic [IDX_W-1:0] req_rd,
    output logic             op_valid,
    output logic [XLEN-1:0]  op_a,
    output logic [XLEN-1:0]  op_b,
    input  logic             res_valid,
    input  logic [XLEN-1:0]  res_data,
    output logic             done,
    inout  wire  [XLEN-1:0]  bus,
    output logic [IDX_W-1:0] reg_idx,
    output logic             reg_en,
    output logic             reg_write
);

    seq_state_t       state_q;
    logic [IDX_W-1:0] rs1_q;
    logic [IDX_W-1:0] rs2_q;
    logic [IDX_W-1:0] rd_q;
    logic             use2_q;
    logic [XLEN-1:0]  op_a_q;
    logic [XLEN-1:0]  op_b_q;
    logic [XLEN-1:0]  wdata_q;
    logic             done_q;
    logic             drive;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            use2_q  <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        rs1_q   <= req_rs1;
                        rs2_q   <= req_rs2;
                        use2_q  <= req_use2;
                        rd_q    <= req_rd;
                        state_q <= RD_A;
                    end
                end
                RD_A: begin
                    op_a_q <= bus;
                    if (use2_q) begin
                        state_q <= RD_B;
                    end else begin
                        op_b_q  <= '0;
                        state_q <= EXEC;
                    end
                end
                RD_B: begin
                    op_b_q  <= bus;
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (res_valid) begin
                        wdata_q <= res_data;
                        // rd == 0 means the result is discarded: retire without a write cycle
                        if (rd_q != '0) begin
                            state_q <= WR;
                        end else begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                WR: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        reg_idx = '0;
        case (state_q)
            RD_A:    reg_idx = rs1_q;
            RD_B:    reg_idx = rs2_q;
            WR:      reg_idx = rd_q;
            default: reg_idx = '0;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign op_valid  = (state_q == EXEC);
    assign reg_en    = (state_q == RD_A) || (state_q == RD_B);
    assign reg_write = (state_q == WR);
    assign drive     = (state_q == WR);
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign done      = done_q;

    // Only WR drives; reg_en is never high in WR, so the bus cannot contend
    assign bus = drive ? wdata_q : {XLEN{1'bz}};

endmodule

// File: tb/tb_regbus_sequencer.sv
// Bench: register-file and adder models around the sequencer, directed table plus randomized requests.
module tb_regbus_sequencer;
    import regbus_pkg::*;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [IDX_W-1:0] req_rs1;
    logic [IDX_W-1:0] req_rs2;
    logic             req_use2;
    logic [IDX_W-1:0] req_rd;
    logic             op_valid;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic             res_valid;
    logic [XLEN-1:0]  res_data;
    logic             done;
    wire  [XLEN-1:0]  bus;
    logic [IDX_W-1:0] reg_idx;
    logic             reg_en;
    logic             reg_write;

    logic [XLEN-1:0]  rf [NREG];
    logic [XLEN-1:0]  rf_rd;
    logic             pl_en;
    logic [IDX_W-1:0] pl_idx;
    logic [XLEN-1:0]  pl_data;

    logic [XLEN-1:0]  m [NREG];
    int               n_vec;
    int               n_err;

    regbus_sequencer u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_use2  (req_use2),
        .req_rd    (req_rd),
        .op_valid  (op_valid),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_data  (res_data),
        .done      (done),
        .bus       (bus),
        .reg_idx   (reg_idx),
        .reg_en    (reg_en),
        .reg_write (reg_write)
    );

    // Register file: r0 reads as zero, drives the bus on reg_en, captures it on reg_write
    assign rf_rd = (reg_idx == '0) ? '0 : rf[reg_idx];
    assign bus   = reg_en ? rf_rd : {XLEN{1'bz}};

    always @(posedge clk) begin
        if (pl_en) rf[pl_idx] <= pl_data;
        else if (reg_write && reg_idx != '0) rf[reg_idx] <= bus;
    end

    // Execute unit is a plain adder
    assign res_data = op_a + op_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [IDX_W-1:0] rs1;
        logic [IDX_W-1:0] rs2;
        bit               use2;
        logic [IDX_W-1:0] rd;
        int               dly;
        logic [XLEN-1:0]  exp_val;
        int               exp_lat;
        int               exp_reads;
        int               exp_writes;
    } vec_t;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit released();
        return (bus === {XLEN{1'bz}}) || (bus == '0);
    endfunction

    task automatic preload(input logic [IDX_W-1:0] idx, input logic [XLEN-1:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = val;
        @(negedge clk);
        pl_en = 1'b0;
        m[idx] = val;
    endtask

    task automatic model_apply(input logic [IDX_W-1:0] rs1, input logic [IDX_W-1:0] rs2,
                               input bit use2, input logic [IDX_W-1:0] rd,
                               output logic [XLEN-1:0] a, output logic [XLEN-1:0] b);
        a = (rs1 == '0) ? '0 : m[rs1];
        b = !use2 ? '0 : ((rs2 == '0) ? '0 : m[rs2]);
        if (rd != '0) m[rd] = a + b;
    endtask

    task automatic chk_regfile(input string name);
        int bad;
        bad = 0;
        for (int i = 1; i < NREG; i++) if (rf[i] !== m[i]) bad++;
        chk(name, bad, 0);
    endtask

    task automatic run_req(input logic [IDX_W-1:0] rs1, input logic [IDX_W-1:0] rs2,
                           input bit use2, input logic [IDX_W-1:0] rd, input int dly,
                           input bit rnd, output int lat, output int writes, output int reads,
                           output int dones, output bit hold_ok,
                           output logic [XLEN-1:0] a_seen, output logic [XLEN-1:0] b_seen);
        int ex;
        bit first;
        lat = -1; writes = 0; reads = 0; dones = 0; hold_ok = 1'b1;
        ex = 0; first = 1'b1; a_seen = '0; b_seen = '0;
        @(negedge clk);
        chk("accept_ready", req_ready, 1);
        req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2; req_use2 = use2; req_rd = rd;
        res_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(negedge clk);
            if (rnd) begin
                req_valid = 1'($urandom_range(0, 1));
                req_rs1 = IDX_W'($urandom); req_rs2 = IDX_W'($urandom); req_rd = IDX_W'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            if (reg_en) reads++;
            if (reg_write) writes++;
            if (done) dones++;
            if (op_valid) begin
                if (first) begin
                    a_seen = op_a; b_seen = op_b; first = 1'b0;
                end else if (op_a !== a_seen || op_b !== b_seen) begin
                    hold_ok = 1'b0;
                end
                if (reg_en || reg_write || !released()) hold_ok = 1'b0;
                res_valid = (ex == dly);
                ex++;
            end else begin
                res_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (done) begin
                lat = c; req_valid = 1'b0; res_valid = 1'b0;
            end
        end
        req_valid = 1'b0; res_valid = 1'b0;
        @(negedge clk);
        if (done) dones++;
    endtask

    initial begin
        vec_t vt[5];
        int lat, writes, reads, dones, waited;
        bit hold_ok;
        logic [XLEN-1:0] a_seen, b_seen, a_exp, b_exp;
        logic [IDX_W-1:0] rs1, rs2, rd;
        bit use2;
        int dly;

        vt[0] = '{5'd1, 5'd2, 1'b1, 5'd3, 0, 32'h30, 5, 2, 1};
        vt[1] = '{5'd1, 5'd2, 1'b0, 5'd4, 0, 32'h10, 4, 1, 1};
        vt[2] = '{5'd1, 5'd2, 1'b1, 5'd0, 0, 32'h0,  4, 2, 0};
        vt[3] = '{5'd3, 5'd1, 1'b1, 5'd5, 6, 32'h40, 11, 2, 1};
        vt[4] = '{5'd5, 5'd5, 1'b1, 5'd5, 2, 32'h80, 7, 2, 1};

        n_vec = 0; n_err = 0;
        rst = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_use2 = 1'b0; req_rd = '0;
        res_valid = 1'b0; pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        for (int i = 0; i < NREG; i++) m[i] = '0;

        // Reset held two cycles, then check the idle state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_reg_en", reg_en, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_bus_released", released(), 1);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        rst = 1'b0;

        for (int i = 1; i < NREG; i++) preload(IDX_W'(i), $urandom);
        preload(5'd1, 32'h10);
        preload(5'd2, 32'h20);

        for (int i = 0; i < 5; i++) begin
            model_apply(vt[i].rs1, vt[i].rs2, vt[i].use2, vt[i].rd, a_exp, b_exp);
            run_req(vt[i].rs1, vt[i].rs2, vt[i].use2, vt[i].rd, vt[i].dly, 1'b0,
                    lat, writes, reads, dones, hold_ok, a_seen, b_seen);
            chk($sformatf("dir%0d_latency", i), lat, vt[i].exp_lat);
            chk($sformatf("dir%0d_reads", i), reads, vt[i].exp_reads);
            chk($sformatf("dir%0d_writes", i), writes, vt[i].exp_writes);
            chk($sformatf("dir%0d_done_pulses", i), dones, 1);
            chk($sformatf("dir%0d_exec_hold", i), hold_ok, 1);
            chk($sformatf("dir%0d_op_a", i), a_seen, a_exp);
            chk($sformatf("dir%0d_op_b", i), b_seen, b_exp);
            if (vt[i].rd != '0) chk($sformatf("dir%0d_result", i), rf[vt[i].rd], vt[i].exp_val);
            chk_regfile($sformatf("dir%0d_regfile", i));
        end

        // Reset while waiting in EXEC: abort without writing r6
        @(negedge clk);
        req_valid = 1'b1; req_rs1 = 5'd1; req_rs2 = 5'd2; req_use2 = 1'b1; req_rd = 5'd6;
        res_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        waited = 0;
        while (!op_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("abort_reached_exec", op_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", req_ready, 1);
        chk("abort_op_valid", op_valid, 0);
        chk("abort_op_a", op_a, 0);
        writes = 0; dones = 0;
        for (int c = 0; c < 5; c++) begin
            if (reg_write) writes++;
            if (done) dones++;
            @(negedge clk);
        end
        chk("abort_no_write", writes, 0);
        chk("abort_no_done", dones, 0);
        chk("abort_r6_kept", rf[6], m[6]);

        // Randomized requests against the model, with noise on idle-time inputs
        for (int n = 0; n < 40; n++) begin
            rs1 = IDX_W'($urandom); rs2 = IDX_W'($urandom);
            use2 = 1'($urandom_range(0, 1));
            rd = ($urandom_range(0, 3) == 0) ? '0 : IDX_W'($urandom);
            dly = $urandom_range(0, 4);
            model_apply(rs1, rs2, use2, rd, a_exp, b_exp);
            run_req(rs1, rs2, use2, rd, dly, 1'b1, lat, writes, reads, dones, hold_ok,
                    a_seen, b_seen);
            chk("rnd_latency", lat, 3 + int'(use2) + dly + int'(rd != '0));
            chk("rnd_reads", reads, 1 + int'(use2));
            chk("rnd_writes", writes, int'(rd != '0));
            chk("rnd_done_pulses", dones, 1);
            chk("rnd_exec_hold", hold_ok, 1);
            chk("rnd_op_a", a_seen, a_exp);
            chk("rnd_op_b", b_seen, b_exp);
            chk_regfile("rnd_regfile");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
